// File: rtl/rs_syndrome_calc.sv
// RS(15,9) over GF(16) syndrome calculator.
// Evaluates the received polynomial at alpha^1..alpha^6 by Horner's rule,
// one symbol per clock from the highest coefficient down, and flags any error.
module rs_syndrome_calc #(
   parameter int N_SYMBOLS = 15,
   parameter int TWO_T     = 6,
   parameter int SYM_W     = 4
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [N_SYMBOLS*SYM_W-1:0] recievedWordIn,
   input  logic                       start,
   output logic                       busy,
   output logic                       done,
   output logic [TWO_T*SYM_W-1:0]     syndromes,
   output logic                       syndromeValid,
   output logic                       errorDetected
);

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   // Multiply by alpha^n in GF(16) with x^4 + x + 1; n is constant per
   // instance, so each use collapses to a small XOR network.
   function automatic logic [SYM_W-1:0] mul_alpha_pow(input logic [SYM_W-1:0] x,
                                                      input int n);
      logic [SYM_W-1:0] v;
      v = x;
      for (int k = 0; k < n; k++) begin
         v = {v[2:0], 1'b0} ^ {2'b00, v[3], v[3]};
      end
      return v;
   endfunction

   state_t                     state_q, state_d;
   logic [N_SYMBOLS*SYM_W-1:0] word_q, word_d;
   logic [3:0]                 cnt_q, cnt_d;
   logic [SYM_W-1:0]           acc_q [TWO_T];
   logic [SYM_W-1:0]           acc_d [TWO_T];
   logic [TWO_T*SYM_W-1:0]     synd_q, synd_d;
   logic                       busy_q, busy_d;
   logic                       done_q, done_d;
   logic                       valid_q, valid_d;
   logic                       err_q, err_d;

   logic [SYM_W-1:0]           cur_sym;
   logic [SYM_W-1:0]           acc_upd [TWO_T];
   logic [TWO_T*SYM_W-1:0]     synd_new;

   // Select the coefficient addressed by the down-counter.
   always_comb begin
      cur_sym = '0;
      for (int i = 0; i < N_SYMBOLS; i++) begin
         if (cnt_q == 4'(i)) begin
            cur_sym = word_q[SYM_W*i +: SYM_W];
         end
      end
   end

   // One Horner step per syndrome: A_j * alpha^j + r[counter].
   for (genvar gi = 0; gi < TWO_T; gi++) begin : g_horner
      assign acc_upd[gi]                   = mul_alpha_pow(acc_q[gi], gi + 1) ^ cur_sym;
      assign synd_new[SYM_W*gi +: SYM_W]   = acc_upd[gi];
   end

   // Next-state and next-output logic for the IDLE/RUN sequencer.
   always_comb begin
      state_d = state_q;
      word_d  = word_q;
      cnt_d   = cnt_q;
      synd_d  = synd_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      valid_d = valid_q;
      err_d   = err_q;
      for (int j = 0; j < TWO_T; j++) begin
         acc_d[j] = acc_q[j];
      end

      case (state_q)
         IDLE: begin
            if (start) begin
               word_d  = recievedWordIn;
               cnt_d   = 4'(N_SYMBOLS - 1);
               busy_d  = 1'b1;
               valid_d = 1'b0;
               state_d = RUN;
               for (int j = 0; j < TWO_T; j++) begin
                  acc_d[j] = '0;
               end
            end
         end
         RUN: begin
            for (int j = 0; j < TWO_T; j++) begin
               acc_d[j] = acc_upd[j];
            end
            if (cnt_q == 4'd0) begin
               // Last coefficient (X^0): publish the fully evaluated values.
               synd_d  = synd_new;
               busy_d  = 1'b0;
               done_d  = 1'b1;
               valid_d = 1'b1;
               err_d   = |synd_new;
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State register with synchronous reset that aborts any run in progress.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         word_q  <= '0;
         cnt_q   <= '0;
         synd_q  <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         valid_q <= 1'b0;
         err_q   <= 1'b0;
         for (int j = 0; j < TWO_T; j++) begin
            acc_q[j] <= '0;
         end
      end else begin
         state_q <= state_d;
         word_q  <= word_d;
         cnt_q   <= cnt_d;
         synd_q  <= synd_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         valid_q <= valid_d;
         err_q   <= err_d;
         for (int j = 0; j < TWO_T; j++) begin
            acc_q[j] <= acc_d[j];
         end
      end
   end

   assign busy          = busy_q;
   assign done          = done_q;
   assign syndromes     = synd_q;
   assign syndromeValid = valid_q;
   assign errorDetected = err_q;

endmodule

// File: tb/tb_rs_syndrome_calc.sv
// Bench for rs_syndrome_calc: directed and random words checked against a
// log/antilog-table evaluation of r(alpha^j) computed as a plain sum.
module tb_rs_syndrome_calc;

   logic        clk = 1'b0;
   logic        reset;
   logic [59:0] recievedWordIn;
   logic        start;
   logic        busy;
   logic        done;
   logic [23:0] syndromes;
   logic        syndromeValid;
   logic        errorDetected;

   always #5 clk = ~clk;

   rs_syndrome_calc dut (
      .clk           (clk),
      .reset         (reset),
      .recievedWordIn(recievedWordIn),
      .start         (start),
      .busy          (busy),
      .done          (done),
      .syndromes     (syndromes),
      .syndromeValid (syndromeValid),
      .errorDetected (errorDetected)
   );

   int total = 0;
   int bad   = 0;

   logic [3:0] gexp [0:14];
   int         glog [0:15];
   logic [3:0] g_poly [0:6];

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      total++;
      assert (obs === expv) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   function automatic logic [3:0] gf_mul(input logic [3:0] a, input logic [3:0] b);
      if (a == 4'd0 || b == 4'd0) return 4'd0;
      return gexp[(glog[a] + glog[b]) % 15];
   endfunction

   // S_j = sum over i of r_i * alpha^(i*j)
   function automatic logic [23:0] model(input logic [59:0] w);
      logic [23:0] s;
      logic [3:0]  acc;
      s = '0;
      for (int j = 1; j <= 6; j++) begin
         acc = 4'd0;
         for (int i = 0; i < 15; i++) begin
            acc ^= gf_mul(w[4*i +: 4], gexp[(i * j) % 15]);
         end
         s[4*(j-1) +: 4] = acc;
      end
      return s;
   endfunction

   // Codeword c(X) = m(X) * g(X), g(X) = prod (X + alpha^j), j = 1..6
   function automatic logic [59:0] make_codeword(input logic [35:0] msg);
      logic [59:0] c;
      logic [3:0]  sym;
      c = '0;
      for (int i = 0; i < 15; i++) begin
         sym = 4'd0;
         for (int k = 0; k < 9; k++) begin
            if (i - k >= 0 && i - k <= 6) sym ^= gf_mul(msg[4*k +: 4], g_poly[i-k]);
         end
         c[4*i +: 4] = sym;
      end
      return c;
   endfunction

   // Start one computation and follow it to its done pulse. If poke > 0,
   // start is pulsed and the input word scrambled that many cycles into the run.
   task automatic run_word(input string tag, input logic [59:0] w,
                           input logic [23:0] expv, input int poke);
      int busy_cnt;
      int cyc;
      bit seen;
      recievedWordIn = w;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      check({tag, ":valid_clr"}, syndromeValid, 1'b0);
      check({tag, ":busy_on"}, busy, 1'b1);
      busy_cnt = 1;
      cyc = 0;
      seen = 1'b0;
      while (!seen && cyc < 40) begin
         if (poke > 0 && cyc == poke) begin
            start = 1'b1;
            recievedWordIn = ~w;
         end else if (poke > 0 && cyc == poke + 1) begin
            start = 1'b0;
         end
         @(posedge clk); #1;
         cyc++;
         if (busy) busy_cnt++;
         if (done) seen = 1'b1;
      end
      start = 1'b0;
      check({tag, ":done_seen"}, seen, 1'b1);
      check({tag, ":latency"}, cyc, 15);
      check({tag, ":busy_cycles"}, busy_cnt, 15);
      check({tag, ":synd"}, syndromes, expv);
      check({tag, ":err"}, errorDetected, (expv != 24'd0));
      check({tag, ":valid"}, syndromeValid, 1'b1);
      $display("run %s word=%015h synd=%06h err=%b", tag, w, syndromes, errorDetected);
      @(posedge clk); #1;
      check({tag, ":done_pulse"}, done, 1'b0);
      check({tag, ":hold"}, syndromes, expv);
   endtask

   initial begin
      logic [59:0] w;
      logic [59:0] cw;
      logic [59:0] e;
      logic [23:0] sum;
      int          t;
      int          last;
      int          ndone;
      int          dcnt;
      bit          pending;

      gexp[0] = 4'd1;
      glog[0] = 0;
      glog[1] = 0;
      for (int i = 1; i < 15; i++) begin
         gexp[i] = {gexp[i-1][2:0], 1'b0} ^ (gexp[i-1][3] ? 4'b0011 : 4'b0000);
         glog[gexp[i]] = i;
      end
      g_poly[0] = 4'd1;
      for (int k = 1; k <= 6; k++) g_poly[k] = 4'd0;
      for (int j = 1; j <= 6; j++) begin
         for (int k = 6; k >= 1; k--) g_poly[k] = g_poly[k-1] ^ gf_mul(g_poly[k], gexp[j]);
         g_poly[0] = gf_mul(g_poly[0], gexp[j]);
      end

      reset = 1'b1;
      start = 1'b0;
      recievedWordIn = '0;
      repeat (2) @(posedge clk);
      #1;
      check("rst:busy", busy, 1'b0);
      check("rst:done", done, 1'b0);
      check("rst:valid", syndromeValid, 1'b0);
      check("rst:err", errorDetected, 1'b0);
      check("rst:synd", syndromes, 24'h0);
      reset = 1'b0;
      @(posedge clk); #1;

      run_word("zero", 60'h0, 24'h000000, 0);
      w = '0; w[7:4] = 4'b1110;
      run_word("sym1", w, 24'h4219DF, 0);
      w = '0; w[59:56] = 4'b0001;
      run_word("sym14", w, 24'hA7EFD9, 0);
      w = '0; w[3:0] = 4'b0001;
      run_word("sym0", w, 24'h111111, 0);

      cw = make_codeword(36'h0000000E0);
      run_word("codeword", cw, 24'h000000, 0);
      e = '0;
      e[15:12] = 4'b0001; e[19:16] = 4'b1000; e[23:20] = 4'b0101; e[47:44] = 4'b0101;
      sum = '0;
      for (int i = 0; i < 15; i++) begin
         w = '0;
         w[4*i +: 4] = e[4*i +: 4];
         sum ^= model(w);
      end
      run_word("cw_err", cw ^ e, sum, 0);
      check("cw_err:model", syndromes, model(cw ^ e));

      for (int n = 0; n < 4; n++) begin
         w = {$urandom, $urandom};
         run_word("random", w, model(w), 0);
      end
      for (int n = 0; n < 2; n++) begin
         cw = make_codeword({$urandom, $urandom});
         run_word("rand_cw", cw, 24'h000000, 0);
      end

      w = {$urandom, $urandom};
      run_word("poke", w, model(w), 3);

      // Reset part way through a run.
      recievedWordIn = {$urandom, $urandom};
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (7) @(posedge clk);
      #1;
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      check("abort:busy", busy, 1'b0);
      check("abort:done", done, 1'b0);
      check("abort:valid", syndromeValid, 1'b0);
      check("abort:err", errorDetected, 1'b0);
      check("abort:synd", syndromes, 24'h0);
      dcnt = 0;
      for (int c = 0; c < 20; c++) begin
         @(posedge clk); #1;
         if (done || busy) dcnt++;
      end
      check("abort:quiet", dcnt, 0);
      $display("run abort busy=%b valid=%b synd=%06h", busy, syndromeValid, syndromes);

      // Reset and start together: reset wins.
      reset = 1'b1;
      start = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      start = 1'b0;
      check("rst_start:busy", busy, 1'b0);
      @(posedge clk); #1;
      check("rst_start:busy2", busy, 1'b0);

      // Start held high: back-to-back runs.
      w = {$urandom, $urandom};
      recievedWordIn = w;
      start = 1'b1;
      @(posedge clk); #1;
      t = 0; last = 0; ndone = 0; pending = 1'b0;
      while (ndone < 3 && t < 80) begin
         @(posedge clk); #1;
         t++;
         if (pending) begin
            check("held:valid_drop", syndromeValid, 1'b0);
            check("held:rebusy", busy, 1'b1);
            pending = 1'b0;
         end
         if (done) begin
            ndone++;
            check("held:synd", syndromes, model(w));
            check("held:valid", syndromeValid, 1'b1);
            if (ndone > 1) check("held:gap", t - last, 16);
            $display("run held#%0d t=%0d synd=%06h", ndone, t, syndromes);
            last = t;
            if (ndone < 3) pending = 1'b1;
            else start = 1'b0;
         end
      end
      start = 1'b0;
      check("held:count", ndone, 3);
      @(posedge clk); #1;
      check("held:idle", busy, 1'b0);
      check("held:valid_end", syndromeValid, 1'b1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
